// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: read-side master for sync_fifo. Issues FIFO reads under a
// credit rule, captures the 1-cycle-late read data into a small circular skid
// buffer and presents the buffer head as a valid/ready stream.
//
// Ports:
//   clk, rst        single clock; synchronous active-high reset
//   fifo_rd_en      read strobe to the FIFO (combinational)
//   fifo_rd_empty   FIFO empty flag
//   fifo_rd_data    FIFO read data, valid the cycle after an accepted read
//   m_valid/m_ready output stream handshake
//   m_data          output word (head of skid buffer)
//   word_cnt        saturating popped-word counter, present only when
//                   SYNC_FIFO_READER_CNT_EN is defined
//
// Parameters: DATA_WIDTH (word width), BUF_DEPTH (skid entries, 2..4).
module sync_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef SYNC_FIFO_READER_CNT_EN
    ,
    output logic [15:0]           word_cnt
`endif
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // Two spare bits so occ + inflight - pop never wraps.
    localparam int unsigned CNT_W = PTR_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  pop;

    // Circular pointer increment; wraps at BUF_DEPTH even when not a power of 2.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    // Outputs depend only on registered state (and rst), never on m_ready.
    assign m_valid = !rst && (occ_q != '0);
    assign m_data  = rst ? '0 : mem_q[head_q];

    // Credit check and next-state computation.
    always_comb begin
        pop        = m_valid & m_ready;
        occ_d      = occ_q + CNT_W'(inflight_q) - CNT_W'(pop);
        head_d     = head_q;
        tail_d     = tail_q;
        // A slot is free for a new read only if it stays free after this cycle.
        fifo_rd_en = !rst && !fifo_rd_empty && (occ_d < DEPTH_C);
        inflight_d = fifo_rd_en;
        if (inflight_q) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
    end

    // State registers; capture only on inflight cycles so undriven data is never sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            if (inflight_q) begin
                mem_q[tail_q] <= fifo_rd_data;
            end
        end
    end

`ifdef SYNC_FIFO_READER_CNT_EN
    logic [15:0] word_cnt_q;

    // Saturating count of accepted output words.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else if (pop && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: behavioural sync_fifo model on the read side,
// scoreboard of words written into the FIFO, table of per-cycle vectors for
// reset and basic latency, and hand-written sequences for the rest.
module tb_sync_fifo_reader;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_rd_en;
    logic          fifo_rd_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = 8'hEE;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
`ifdef SYNC_FIFO_READER_CNT_EN
    logic [15:0]   word_cnt;
`endif

    sync_fifo_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef SYNC_FIFO_READER_CNT_EN
        ,
        .word_cnt     (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    logic [DW-1:0] fq[$];     // FIFO model contents
    logic [DW-1:0] exp_q[$];  // scoreboard: words expected on the stream
    logic [DW-1:0] pend[$];   // words to write into the FIFO at the next edge

    typedef struct {
        bit            push;
        logic [DW-1:0] pdata;
        bit            rdy;
        bit            rs;
        bit            e_rden;
        bit            e_valid;
        bit            chk_data;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare a popped output word against the scoreboard head.
    task automatic sb_pop();
        logic [DW-1:0] e;
        total++;
        n_out++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got word %0h expected none (t=%0t)", m_data, $time);
        end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
                bad++;
                $display("FAIL sb_data: got %0h expected %0h (t=%0t)", m_data, e, $time);
            end
        end
    endtask

    // Called at a negedge: consume this cycle's handshake, advance one clock,
    // update the FIFO model and apply the next cycle's inputs, return at negedge.
    task automatic step(input bit rdy, input bit rs);
        bit re;
        re = fifo_rd_en;
        if (m_valid && m_ready) sb_pop();
        @(posedge clk);
        #1;
        if (rst) begin
            fq.delete();
            exp_q.delete();
            fifo_rd_data = 8'hEE;
        end else if (re) begin
            total++;
            if (fq.size() == 0) begin
                bad++;
                $display("FAIL rd_underflow: got read on empty FIFO expected no read (t=%0t)", $time);
                fifo_rd_data = 8'hEE;
            end else begin
                fifo_rd_data = fq.pop_front();
            end
        end else begin
            fifo_rd_data = 8'hEE;
        end
        foreach (pend[i]) begin
            fq.push_back(pend[i]);
            exp_q.push_back(pend[i]);
        end
        pend.delete();
        fifo_rd_empty = (fq.size() == 0);
        m_ready = rdy;
        rst = rs;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    initial begin
        int first_v, last_v, nv;
        logic [DW-1:0] held;

        // reset cycles, then single-word latency
        tbl[0] = '{0, 8'h00, 0, 1, 0, 0, 1, 8'h00};
        tbl[1] = '{1, 8'h55, 1, 1, 0, 0, 1, 8'h00};  // non-empty FIFO during reset: no read
        tbl[2] = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00};  // FIFO flushed with the reader
        tbl[3] = '{1, 8'h11, 1, 0, 1, 0, 0, 8'h00};  // read cycle
        tbl[4] = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00};  // capture cycle
        tbl[5] = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h11};  // visible
        tbl[6] = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00};  // drained

        @(negedge clk);
        for (int r = 0; r < 7; r++) begin
            if (tbl[r].push) pend.push_back(tbl[r].pdata);
            step(tbl[r].rdy, tbl[r].rs);
            check($sformatf("vec%0d_rd_en", r), 32'(fifo_rd_en), 32'(tbl[r].e_rden));
            check($sformatf("vec%0d_valid", r), 32'(m_valid), 32'(tbl[r].e_valid));
            if (tbl[r].chk_data)
                check($sformatf("vec%0d_data", r), 32'(m_data), 32'(tbl[r].e_data));
        end
        check("t1_drain", 32'(exp_q.size()), 32'd0);

        // streaming 16 words
        do_reset();
        for (int i = 1; i <= 16; i++) pend.push_back(DW'(i));
        n_out = 0; nv = 0; first_v = -1; last_v = -1;
        for (int c = 0; c < 22; c++) begin
            step(1'b1, 1'b0);
            if (m_valid) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        check("t2_first_valid", 32'(first_v), 32'd2);
        check("t2_valid_cycles", 32'(nv), 32'd16);
        check("t2_no_bubble", 32'(last_v - first_v + 1), 32'd16);
        step(1'b1, 1'b0);
        check("t2_words", 32'(n_out), 32'd16);
`ifdef SYNC_FIFO_READER_CNT_EN
        check("t6_cnt16", 32'(word_cnt), 32'd16);
`endif

        // backpressure in cycles 4-9
        do_reset();
        for (int i = 1; i <= 16; i++) pend.push_back(DW'(8'h20 + i));
        n_out = 0; held = '0;
        for (int c = 0; c < 30; c++) begin
            step(!(c >= 4 && c <= 9), 1'b0);
            if (c == 4) held = m_data;
            if (c >= 5 && c <= 9) begin
                check($sformatf("t3_hold_c%0d", c), 32'(m_data), 32'(held));
                check($sformatf("t3_valid_c%0d", c), 32'(m_valid), 32'd1);
                check($sformatf("t3_rd_en_c%0d", c), 32'(fifo_rd_en), 32'd0);
            end
        end
        check("t3_words", 32'(n_out), 32'd16);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // FIFO empties mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) pend.push_back(DW'(8'h40 + i));
        n_out = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 5) pend.push_back(8'h4F);
            step(1'b1, 1'b0);
            if (c == 5 || c == 6)
                check($sformatf("t4_gap_c%0d", c), 32'(m_valid), 32'd0);
            if (c == 7) begin
                check("t4_fourth_valid", 32'(m_valid), 32'd1);
                check("t4_fourth_data", 32'(m_data), 32'h4F);
            end
        end
        check("t4_words", 32'(n_out), 32'd4);
        check("t4_drain", 32'(exp_q.size()), 32'd0);

        // reset with inflight=1 and occ=1
        do_reset();
        for (int i = 0; i < 3; i++) pend.push_back(DW'(8'h60 + i));
        step(1'b0, 1'b0);   // c0: read
        step(1'b0, 1'b0);   // c1: read, capture
        step(1'b0, 1'b1);   // c2: occ=1, inflight=1, rst high
        check("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t5_rst_valid", 32'(m_valid), 32'd0);
        step(1'b1, 1'b0);   // c3: after reset
        check("t5_post_valid", 32'(m_valid), 32'd0);
        check("t5_post_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t5_post_data", 32'(m_data), 32'd0);
        check("t5_sb_flushed", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) pend.push_back(DW'(8'hA1 + i));
        n_out = 0;
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
        check("t5_words", 32'(n_out), 32'd4);
        check("t5_drain", 32'(exp_q.size()), 32'd0);

`ifdef SYNC_FIFO_READER_CNT_EN
        // counter saturation and clear
        do_reset();
        check("t6_cnt_reset", 32'(word_cnt), 32'd0);
        n_out = 0;
        for (int i = 0; i < 65545; i++) begin
            pend.push_back(DW'(i));
            step(1'b1, 1'b0);
        end
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0);
        check("t6_pops", 32'(n_out >= 65540), 32'd1);
        check("t6_cnt_sat", 32'(word_cnt), 32'hFFFF);
        do_reset();
        check("t6_cnt_clear", 32'(word_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
